// File: rtl/cache_pkg.sv
// Shared defaults and types for the cache refill controller.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package cache_pkg;

   // Default geometry: 64-bit addresses, 64-bit bank words, 4 words per line.
   localparam int DEF_ADDR_WIDTH = 64;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_BANK_NUM   = 4;

   // Each memory beat carries two bank words, so a line takes half as many
   // beats as it has words.
   function automatic int nbeat(input int bank_num);
      return bank_num / 2;
   endfunction

   localparam int DEF_NBEAT = nbeat(DEF_BANK_NUM);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_RD   = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional victim writeback, then line refill.
// Latency: clean miss NBEAT+2 cycles capture->finish_rd with zero-wait memory; dirty adds NBEAT.
// Backpressure: each beat holds mem_req and its fields stable until mem_ready; no other stall.
//
// Ports:
//   clk, rstn                  clock, async active-low reset
//   miss_cache/need_wb         refill request (sampled only in IDLE) and dirty-victim flag
//   addr_cache/set_cache       refill line address and way, latched on capture
//   addr_wb/data_wb            victim line address and data, latched on capture
//   busy_wb/busy_rd            writeback / refill in progress
//   addr_rd/data_rd/wen_rd     refill beat write into the data array (one-cycle strobe)
//   set_rd/finish_rd           refill way, refill-complete pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata  beat interface to memory
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = cache_pkg::DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = cache_pkg::DEF_DATA_WIDTH,
   parameter int BANK_NUM   = cache_pkg::DEF_BANK_NUM
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             miss_cache,
   input  logic                             need_wb,
   input  logic [ADDR_WIDTH-1:0]            addr_cache,
   input  logic                             set_cache,
   input  logic [ADDR_WIDTH-1:0]            addr_wb,
   input  logic [BANK_NUM*DATA_WIDTH-1:0]   data_wb,
   output logic                             busy_wb,
   output logic                             busy_rd,
   output logic [ADDR_WIDTH-1:0]            addr_rd,
   output logic [2*DATA_WIDTH-1:0]          data_rd,
   output logic                             wen_rd,
   output logic                             set_rd,
   output logic                             finish_rd,
   output logic                             mem_req,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [2*DATA_WIDTH-1:0]          mem_wdata,
   input  logic                             mem_ready,
   input  logic [2*DATA_WIDTH-1:0]          mem_rdata
);

   localparam int NBEAT  = nbeat(BANK_NUM);
   localparam int BEAT_W = 2 * DATA_WIDTH;
   localparam int LINE_W = BANK_NUM * DATA_WIDTH;
   // Counter must also hold NBEAT: that value marks the drain cycle in RD.
   localparam int CNT_W  = $clog2(NBEAT + 1);

   localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 4);
   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(NBEAT - 1);
   localparam logic [CNT_W-1:0]      CNT_DRAIN  = CNT_W'(NBEAT);
   localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    wen_q, wen_d;
   logic [BEAT_W-1:0]       data_rd_q, data_rd_d;
   logic [ADDR_WIDTH-1:0]   addr_rd_q, addr_rd_d;

   // Line buffer: not reset, only meaningful after a capture.
   logic [ADDR_WIDTH-1:0]   rd_base_q, rd_base_d;
   logic [ADDR_WIDTH-1:0]   wb_base_q, wb_base_d;
   logic                    set_q, set_d;
   logic [LINE_W-1:0]       line_q, line_d;

   logic                    rd_active;
   logic                    wb_active;
   logic                    beat_ok;
   logic [ADDR_WIDTH-1:0]   beat_off;
   logic [ADDR_WIDTH-1:0]   rd_beat_addr;
   logic [ADDR_WIDTH-1:0]   wb_beat_addr;
   logic [BEAT_W-1:0]       wb_beat;
   int                      wb_sel;

   // ---------------------------------------------------------------------
   // Beat addressing and memory request
   // ---------------------------------------------------------------------
   always_comb begin
      wb_active    = (state_q == ST_WB);
      // The drain cycle (counter == NBEAT) sits in RD but issues no request;
      // it exists so the last wen_rd and finish_rd never overlap.
      rd_active    = (state_q == ST_RD) && (cnt_q != CNT_DRAIN);
      beat_ok      = (wb_active || rd_active) && mem_ready;
      beat_off     = ADDR_WIDTH'(cnt_q) * BEAT_BYTES;
      rd_beat_addr = rd_base_q + beat_off;
      wb_beat_addr = wb_base_q + beat_off;
      wb_sel       = int'(cnt_q) * BEAT_W;
      wb_beat      = line_q[wb_sel +: BEAT_W];
   end

   assign mem_req   = wb_active || rd_active;
   assign mem_we    = wb_active;
   assign mem_addr  = wb_active ? wb_beat_addr : (rd_active ? rd_beat_addr : '0);
   assign mem_wdata = wb_active ? wb_beat : '0;

   assign busy_wb   = wb_active;
   assign busy_rd   = (state_q != ST_IDLE);
   assign finish_rd = (state_q == ST_FIN);
   assign wen_rd    = wen_q;
   assign data_rd   = data_rd_q;
   assign addr_rd   = addr_rd_q;
   // Gated so it reads 0 whenever the block is idle or in reset.
   assign set_rd    = set_q & busy_rd;

   // ---------------------------------------------------------------------
   // FSM and next-state datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wen_d     = 1'b0;
      data_rd_d = data_rd_q;
      addr_rd_d = addr_rd_q;
      rd_base_d = rd_base_q;
      wb_base_d = wb_base_q;
      set_d     = set_q;
      line_d    = line_q;

      case (state_q)
         ST_IDLE: begin
            if (miss_cache) begin
               rd_base_d = addr_cache;
               wb_base_d = addr_wb;
               set_d     = set_cache;
               line_d    = data_wb;
               cnt_d     = '0;
               state_d   = need_wb ? ST_WB : ST_RD;
            end
         end
         ST_WB: begin
            if (beat_ok) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_RD;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         ST_RD: begin
            if (cnt_q == CNT_DRAIN) begin
               // Last beat is being written this cycle; present the line
               // base for the finish pulse that follows.
               state_d   = ST_FIN;
               addr_rd_d = rd_base_q;
            end else if (beat_ok) begin
               cnt_d     = cnt_q + CNT_ONE;
               wen_d     = 1'b1;
               data_rd_d = mem_rdata;
               addr_rd_d = rd_beat_addr;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wen_q     <= 1'b0;
         data_rd_q <= '0;
         addr_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wen_q     <= wen_d;
         data_rd_q <= data_rd_d;
         addr_rd_q <= addr_rd_d;
      end
   end

   always_ff @(posedge clk) begin
      rd_base_q <= rd_base_d;
      wb_base_q <= wb_base_d;
      set_q     <= set_d;
      line_q    <= line_d;
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: random misses against a transaction-level model.
// Latency: expected finish latency derived from beat count and memory wait states.
// Backpressure: memory responder inserts 0..3 wait cycles per beat.
module tb_cache_refill_ctrl;
   import cache_pkg::*;

   localparam int AW = DEF_ADDR_WIDTH;
   localparam int DW = DEF_DATA_WIDTH;
   localparam int BN = DEF_BANK_NUM;
   localparam int NB = BN / 2;
   localparam int BW = 2 * DW;
   localparam int LW = BN * DW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          miss_cache = 1'b0;
   logic          need_wb = 1'b0;
   logic [AW-1:0] addr_cache = '0;
   logic          set_cache = 1'b0;
   logic [AW-1:0] addr_wb = '0;
   logic [LW-1:0] data_wb = '0;
   logic          busy_wb, busy_rd, wen_rd, set_rd, finish_rd;
   logic [AW-1:0] addr_rd, mem_addr;
   logic [BW-1:0] data_rd, mem_wdata;
   logic          mem_req, mem_we;
   logic          mem_ready = 1'b0;
   logic [BW-1:0] mem_rdata = '0;

   cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) dut (
      .clk(clk), .rstn(rstn), .miss_cache(miss_cache), .need_wb(need_wb),
      .addr_cache(addr_cache), .set_cache(set_cache), .addr_wb(addr_wb), .data_wb(data_wb),
      .busy_wb(busy_wb), .busy_rd(busy_rd), .addr_rd(addr_rd), .data_rd(data_rd),
      .wen_rd(wen_rd), .set_rd(set_rd), .finish_rd(finish_rd), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [AW-1:0] addr; logic [BW-1:0] wdata; } mem_t;
   typedef struct { logic [AW-1:0] addr; logic [BW-1:0] data; } wen_t;
   typedef struct { logic set; logic [AW-1:0] addr; int lat; int wbc; } fin_t;

   mem_t exp_mem[$];
   wen_t exp_wen[$];
   fin_t exp_fin[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int cap_cyc = 0;
   int wait_n = 0;
   int wcnt = 0;
   int busy_wb_cnt = 0;
   int wen_cnt = 0;
   logic          stall_prev = 1'b0;
   logic          stall_we;
   logic [AW-1:0] stall_addr;
   logic [BW-1:0] stall_wdata;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event seen, expected none", name);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctrl"}, {busy_wb, busy_rd, wen_rd, set_rd, finish_rd, mem_req, mem_we}, '0);
      chk({tag, "_addr"}, {addr_rd, mem_addr}, '0);
      chk({tag, "_data"}, {data_rd, mem_wdata}, '0);
   endtask

   always @(posedge clk) cyc++;

   // Memory responder followed by the scoreboard monitor; both act at the
   // falling edge, so mem_ready is settled before the handshake is judged.
   always @(negedge clk) begin
      if (!rstn) begin
         stall_prev = 1'b0;
         wcnt = 0;
         mem_ready = (wait_n == 0);
      end else begin
         if (wait_n == 0) begin
            mem_ready = 1'b1;
         end else if (mem_req) begin
            mem_ready = (wcnt == wait_n);
            wcnt = (wcnt == wait_n) ? 0 : wcnt + 1;
         end else begin
            mem_ready = 1'b0;
            wcnt = 0;
         end
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};

         if (stall_prev) begin
            chk("stall_req", mem_req, 1'b1);
            chk("stall_we", mem_we, stall_we);
            chk("stall_addr", mem_addr, stall_addr);
            chk("stall_wdata", mem_wdata, stall_wdata);
         end
         stall_prev = mem_req && !mem_ready;
         stall_we = mem_we;
         stall_addr = mem_addr;
         stall_wdata = mem_wdata;

         if (mem_req && mem_ready) begin
            if (exp_mem.size() == 0) begin
               flag("unexpected_mem_beat");
            end else begin
               mem_t m;
               m = exp_mem.pop_front();
               chk("mem_we", mem_we, m.we);
               chk("mem_addr", mem_addr, m.addr);
               if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
               else exp_wen.push_back('{addr: m.addr, data: mem_rdata});
            end
         end

         if (busy_wb) busy_wb_cnt++;

         if (wen_rd) begin
            wen_cnt++;
            chk("wen_with_finish", finish_rd, 1'b0);
            if (exp_wen.size() == 0) begin
               flag("unexpected_wen_rd");
            end else begin
               wen_t w;
               w = exp_wen.pop_front();
               chk("wen_addr", addr_rd, w.addr);
               chk("wen_data", data_rd, w.data);
               if (exp_fin.size() != 0) chk("wen_set", set_rd, exp_fin[0].set);
            end
         end

         if (finish_rd) begin
            if (exp_fin.size() == 0) begin
               flag("unexpected_finish_rd");
            end else begin
               fin_t f;
               f = exp_fin.pop_front();
               chk("fin_set", set_rd, f.set);
               chk("fin_addr", addr_rd, f.addr);
               chk("fin_busy_rd", busy_rd, 1'b1);
               chk("fin_latency", cyc - cap_cyc, f.lat);
               chk("busy_wb_cycles", busy_wb_cnt, f.wbc);
               chk("wen_pulses", wen_cnt, NB);
               chk("fin_beats_pending", exp_wen.size() + exp_mem.size(), 0);
            end
         end
      end
   end

   task automatic flush();
      exp_mem.delete();
      exp_wen.delete();
      exp_fin.delete();
   endtask

   // Issue one miss at the current cycle (called just after a rising edge)
   // and queue what the line transfer must look like.
   task automatic do_miss(input logic dirty, input logic [AW-1:0] a, input logic s,
                          input logic [AW-1:0] wa, input logic [LW-1:0] d);
      int n = 0;
      int per_beat;
      while (busy_rd && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy_rd) begin
         flag("idle_timeout");
         flush();
      end
      miss_cache = 1'b1;
      need_wb = dirty;
      addr_cache = a;
      set_cache = s;
      addr_wb = wa;
      data_wb = d;
      per_beat = wait_n + 1;
      if (dirty)
         for (int b = 0; b < NB; b++)
            exp_mem.push_back('{we: 1'b1, addr: wa + AW'(b * (DW / 4)), wdata: d[b*BW +: BW]});
      for (int b = 0; b < NB; b++)
         exp_mem.push_back('{we: 1'b0, addr: a + AW'(b * (DW / 4)), wdata: '0});
      exp_fin.push_back('{set: s, addr: a,
                          lat: NB * per_beat * (dirty ? 2 : 1) + 2,
                          wbc: dirty ? NB * per_beat : 0});
      cap_cyc = cyc;
      busy_wb_cnt = 0;
      wen_cnt = 0;
      @(posedge clk); #1;
      miss_cache = 1'b0;
      addr_cache = {$urandom, $urandom};
      set_cache = ~s;
      chk("busy_rd_after_capture", busy_rd, 1'b1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_fin.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_fin.size() != 0) begin
         flag("finish_timeout");
         flush();
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] v;
      v = {$urandom, $urandom};
      v[4:0] = '0;
      return v;
   endfunction

   initial begin
      logic [LW-1:0] pat;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Clean miss, zero-wait memory.
      wait_n = 0;
      do_miss(1'b0, 64'h1000, 1'b1, 64'h0, rand_line());
      wait_done();

      // Dirty miss: two writeback beats before the refill.
      pat = rand_line();
      do_miss(1'b1, 64'h5000, 1'b0, 64'h2000, pat);
      wait_done();

      // Three wait cycles per beat.
      @(posedge clk); #1;
      wait_n = 3;
      do_miss(1'b1, 64'h3000, 1'b1, 64'h4000, rand_line());
      wait_done();
      @(posedge clk); #1;
      wait_n = 0;

      // A second miss while refilling must be ignored.
      do_miss(1'b0, 64'h6000, 1'b0, 64'h0, rand_line());
      miss_cache = 1'b1;
      need_wb = 1'b1;
      addr_cache = 64'h7000;
      @(posedge clk); #1;
      miss_cache = 1'b0;
      wait_done();

      // Reset during the second read beat aborts the refill.
      do_miss(1'b0, 64'h8000, 1'b1, 64'h0, rand_line());
      @(posedge clk); #1;
      rstn = 1'b0;
      flush();
      #1 check_all_zero("midreset");
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      do_miss(1'b0, 64'h9000, 1'b1, 64'h0, rand_line());
      wait_done();

      // Random misses with random wait states.
      for (int t = 0; t < 30; t++) begin
         @(posedge clk); #1;
         wait_n = int'($urandom_range(0, 2));
         do_miss(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                 rand_addr(), rand_line());
         wait_done();
      end

      repeat (3) @(posedge clk);
      #1 chk("queues_empty", exp_mem.size() + exp_wen.size() + exp_fin.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
